muldiv_iter: RTL and testbench
==============================

// Module: muldiv_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit for the EX stage, replacing the fixed
//  32-bit ALU mult/div path. Computes MULT/MULTU/DIV/DIVU one bit per cycle.
//  Drives a stall request to the hazard unit while busy.
//  Delivers a {hi,lo} result for the HILO register write in MEM.
// PARAMETERS
//  WIDTH   32   operand width; hi/lo are WIDTH each; counter width derived = $clog2(WIDTH)+1
// PORTS
//  clk     in   1        rising-edge clock
//  rst     in   1        synchronous reset, active-low
//  start   in   1        request op; sampled only in IDLE
//  op      in   2        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  cancel  in   1        abort in-flight op (EX flush/exception)
//  a       in   WIDTH    rs operand (multiplicand / dividend)
//  b       in   WIDTH    rt operand (multiplier / divisor)
//  busy    out  1        stall request (combinational, see below)
//  done    out  1        one-cycle pulse: hi/lo valid
//  hi      out  WIDTH    MULT: product[2W-1:W]; DIV: remainder
//  lo      out  WIDTH    MULT: product[W-1:0];  DIV: quotient
// BEHAVIOUR
//  - Reset (rst==0 at edge): state=IDLE, busy=0, done=0, hi=0, lo=0; overrides all inputs.
//  - States: IDLE, CALC, SIGN, DONE.
//  - Priority at each edge: rst > cancel > normal transition.
//  - IDLE + start: latch |a|,|b| (signed ops) or a,b (unsigned), sign flags, op; cnt=0 -> CALC.
//    DIV/DIVU with b==0: go straight to DONE with hi=a, lo={WIDTH{1'b1}}.
//  - CALC: one shift-add (mul) or restoring-subtract (div) step per cycle.
//    Exactly WIDTH cycles, then -> SIGN.
//  - SIGN: signed mul: negate 2W product if sign(a)^sign(b).
//    Signed div: quotient negated if sign(a)^sign(b); remainder takes sign(a).
//    Load hi/lo -> DONE.
//  - DONE: done=1 for this one cycle -> IDLE. start is ignored in DONE.
//  - Latency: start in cycle t -> done in cycle t+WIDTH+2 (div-by-zero: t+1).
//  - busy = (state==IDLE & start & ~cancel) | state==CALC | state==SIGN.
//    busy is 0 in the DONE cycle, so EX advances while done is high.
//  - start outside IDLE: ignored, no queueing.
//  - cancel in CALC/SIGN/DONE: -> IDLE next edge; done is not pulsed; hi/lo keep prior values.
//  - cancel with start in the same IDLE cycle: cancel wins, op not accepted.
//  - hi/lo: change only when entering DONE; hold until the next completed op.
//  - Arithmetic: products are full 2*WIDTH; no overflow flag.
//    DIV of -2^(W-1) by -1 gives lo=2^(W-1) (bit pattern), hi=0.
//  - Operand ports are sampled only at acceptance; they may change while busy.
// TESTING (WIDTH=32)
//  1 MULTU a=FFFFFFFF b=FFFFFFFF, start@t -> busy t..t+33, done@t+34; hi=FFFFFFFE lo=00000001
//  2 MULT a=FFFFFFFD(-3) b=00000005 -> hi=FFFFFFFF lo=FFFFFFF1; MULT 0*x -> hi=lo=0
//  3 DIV a=-7 b=2 -> lo=FFFFFFFD hi=FFFFFFFF; DIVU 7/2 -> lo=3 hi=1; DIV 80000000/FFFFFFFF -> lo=80000000 hi=0
//  4 DIVU a=5 b=0 -> done@t+1, hi=00000005 lo=FFFFFFFF, busy only in cycle t
//  5 DIV started, cancel@t+10 -> busy=0 from t+11, no done, hi/lo unchanged.
//    New start@t+12 is accepted; start in mid-CALC has no effect.
//  6 rst=0 mid-CALC -> next edge busy=done=hi=lo=0, state IDLE.
//    Back-to-back ops: start in the cycle after done is accepted.

Source files
------------

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative multiply/divide unit for the EX stage.
// Handles MULT/MULTU/DIV/DIVU and computes one bit per cycle. It raises busy
// (a stall request) while an operation is in flight. It pulses done for one
// cycle, in the cycle where the {hi,lo} result is valid for the HILO write.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous reset, active-low
//   start   request an operation; only looked at in IDLE
//   op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   cancel  abort the in-flight operation (EX flush / exception)
//   a, b    rs / rt operands; sampled only when the operation is accepted
//   busy    stall request to the hazard unit (combinational)
//   done    one-cycle pulse: hi/lo hold the new result
//   hi, lo  product[2W-1:W] / product[W-1:0], or remainder / quotient
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             cancel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
   logic [2*WIDTH-1:0] acc_q, acc_d;
   // dvs holds the multiplicand (mul) or the divisor (div)
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic               div_q, div_d;
   logic               neg_q, neg_d;    // negate product / quotient
   logic               rneg_q, rneg_d;  // negate remainder (sign of dividend)
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

   logic               is_signed, is_div;
   logic [WIDTH-1:0]   a_abs, b_abs;

   // shift-add multiply step, LSB of the multiplier first
   logic [WIDTH:0]     msum;
   logic [2*WIDTH-1:0] mul_nxt;

   // restoring divide step
   logic [WIDTH:0]     rsh, diff;
   logic               qbit;
   logic [WIDTH-1:0]   rnew;
   logic [2*WIDTH-1:0] div_nxt;

   // sign fix-up
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign is_signed = ~op[0];
   assign is_div    = op[1];
   assign a_abs     = (is_signed && a[WIDTH-1]) ? -a : a;
   assign b_abs     = (is_signed && b[WIDTH-1]) ? -b : b;

   assign msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
   assign mul_nxt = {msum, acc_q[WIDTH-1:1]};

   // The remainder stays below the divisor, so after the shift it fits in
   // W+1 bits. The new remainder always fits back in W bits.
   assign rsh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign diff    = rsh - {1'b0, dvs_q};
   assign qbit    = ~diff[WIDTH];
   assign rnew    = qbit ? diff[WIDTH-1:0] : rsh[WIDTH-1:0];
   assign div_nxt = {rnew, acc_q[WIDTH-2:0], qbit};

   // -2^(W-1) / -1 produces a quotient magnitude of 2^(W-1) with neg_q=0.
   // The bit pattern then lands in lo unchanged.
   assign prod_fix = neg_q  ? -acc_q : acc_q;
   assign quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      dvs_d   = dvs_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         S_IDLE: begin
            if (start && !cancel) begin
               cnt_d  = '0;
               div_d  = is_div;
               neg_d  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               rneg_d = is_signed & a[WIDTH-1];
               if (is_div) begin
                  acc_d = {{WIDTH{1'b0}}, a_abs};
                  dvs_d = b_abs;
               end else begin
                  acc_d = {{WIDTH{1'b0}}, b_abs};
                  dvs_d = a_abs;
               end
               if (is_div && (b == '0)) begin
                  // divide by zero skips the iteration entirely
                  hi_d    = a;
                  lo_d    = '1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            acc_d = div_q ? div_nxt : mul_nxt;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = S_SIGN;
         end
         S_SIGN: begin
            if (div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // An abort returns to IDLE and must not disturb a previously delivered result.
      if (cancel && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         dvs_q   <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         dvs_q   <= dvs_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // busy drops in the DONE cycle so that EX advances while done is high
   assign busy = ((state_q == S_IDLE) && start && !cancel)
               || (state_q == S_CALC) || (state_q == S_SIGN);
   assign done = (state_q == S_DONE) && !cancel;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter (WIDTH=32).
// A reference model runs in the compare process. It is built from plain
// 64-bit arithmetic plus a "done due in cycle N" bookkeeping. Every cycle it
// checks busy, done, hi and lo. The stimulus adds literal checks of the
// hand-computed results.
module tb_muldiv_iter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic         cancel;
   logic [W-1:0] a, b;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int total = 0;
   int bad   = 0;

   muldiv_iter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .cancel(cancel),
      .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference result {hi,lo}, computed with plain 64-bit arithmetic.
   function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint          sx, sy, sq, sr;
      longint unsigned ux, uy;
      logic [63:0]     res, qv, rv;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      res = '0;
      case (o)
         2'b00: res = sx * sy;
         2'b01: res = ux * uy;
         default: begin
            if (y == 32'd0) begin
               res = {x, 32'hFFFF_FFFF};
            end else begin
               if (o == 2'b10) begin
                  sq = sx / sy;  sr = sx % sy;
                  qv = sq;       rv = sr;
               end else begin
                  qv = ux / uy;  rv = ux % uy;
               end
               res = {rv[31:0], qv[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   // Model state, owned by the compare process.
   int          cyc = 0;
   int          m_due = -1;     // cycle in which done is expected; -1 when idle
   bit          m_valid = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [63:0] m_pend = '0;

   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy", {63'b0, busy}, {63'b0, (m_due < 0) ? (start && !cancel) : (cyc < m_due)});
         chk("done", {63'b0, done}, {63'b0, (cyc == m_due) && !cancel});
         chk("hi", {32'b0, hi}, {32'b0, m_hi});
         chk("lo", {32'b0, lo}, {32'b0, m_lo});
      end
      // advance the model using the inputs present at the upcoming edge
      if (!rst) begin
         m_due = -1; m_hi = '0; m_lo = '0; m_valid = 1;
      end else if (m_due >= 0) begin
         if (cancel || cyc == m_due) m_due = -1;
      end else if (start && !cancel) begin
         m_pend = ref_res(op, a, b);
         m_due  = cyc + ((op[1] && b == '0) ? 1 : W + 2);
      end
      if (m_due == cyc + 1) begin
         m_hi = m_pend[63:32];
         m_lo = m_pend[31:0];
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      step();
      start = 1'b0;
      // the operands are only sampled at acceptance, so scramble them
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
   endtask

   // Returns at the negedge of the done cycle, or after a bounded number of cycles.
   task automatic wait_done(input string nm);
      bit seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1;
      end
      chk({nm, "_timeout"}, {63'b0, seen}, 64'd1);
   endtask

   task automatic run(input string nm, input logic [1:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [63:0] exp);
      issue(o, x, y);
      wait_done(nm);
      chk(nm, {hi, lo}, exp);
      step();
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;

      // pin the reference model against hand-computed results
      chk("model_multu", ref_res(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
      chk("model_mult",  ref_res(2'b00, 32'hFFFFFFFD, 32'h5), 64'hFFFFFFFF_FFFFFFF1);
      chk("model_div",   ref_res(2'b10, 32'hFFFFFFF9, 32'h2), 64'hFFFFFFFF_FFFFFFFD);
      chk("model_divmin", ref_res(2'b10, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

      repeat (3) step();
      chk("reset_hilo", {hi, lo}, 64'd0);
      chk("reset_busy_done", {62'b0, busy, done}, 64'd0);
      rst = 1'b1;
      step();

      run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
      run("mult_neg",  2'b00, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1);
      run("mult_zero", 2'b00, 32'h00000000, 32'h12345678, 64'd0);
      run("mult_negneg", 2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 64'h00000000_00000006);
      run("div_neg",   2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
      run("div_negneg", 2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003);
      run("divu_7_2",  2'b11, 32'h00000007, 32'h00000002, 64'h00000001_00000003);
      run("div_min",   2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
      run("divu_by0",  2'b11, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF);
      run("div_by0",   2'b10, 32'hFFFFFFF0, 32'h00000000, 64'hFFFFFFF0_FFFFFFFF);

      // cancel at t+10; a start raised mid-CALC is ignored
      issue(2'b10, 32'h00001234, 32'h00000007);   // now in t+1
      repeat (4) step();                          // t+5
      start = 1'b1; op = 2'b01; a = 32'h3; b = 32'h3;
      step();                                     // t+6
      start = 1'b0;
      repeat (4) step();                          // t+10
      cancel = 1'b1;
      step();                                     // t+11
      cancel = 1'b0;
      chk("cancel_busy", {63'b0, busy}, 64'd0);
      chk("cancel_hilo", {hi, lo}, 64'hFFFFFFF0_FFFFFFFF);
      step();                                     // t+12
      run("after_cancel", 2'b11, 32'h00000007, 32'h00000002, 64'h00000001_00000003);

      // synchronous reset in the middle of CALC
      issue(2'b01, 32'h00000003, 32'h00000004);
      repeat (5) step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("rst_mid_hilo", {hi, lo}, 64'd0);
      chk("rst_mid_busy_done", {62'b0, busy, done}, 64'd0);
      step();

      // back-to-back: the second start lands in the cycle after done
      issue(2'b00, 32'hFFFFFFFD, 32'h00000005);
      wait_done("b2b_first");
      chk("b2b_first", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
      step();
      run("b2b_second", 2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);

      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
